// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU feeding the accumulator. Single-cycle ops finish
// at the accepting edge. MUL runs an iterative shift-add over WIDTH cycles.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state,   w_state;
    logic [PW-1:0]    r_mcand,   w_mcand;
    logic [WIDTH-1:0] r_mplier,  w_mplier;
    logic [PW-1:0]    r_prod,    w_prod;
    logic [CW-1:0]    r_cnt,     w_cnt;
    logic [WIDTH-1:0] r_alu_out, w_alu_out;
    logic             r_carry,   w_carry;
    logic             r_zero,    w_zero;
    logic             r_busy,    w_busy;
    logic             r_done,    w_done;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_op_res;
    logic             w_op_carry;
    logic [PW-1:0]    w_prod_sum;

    assign alu_out = r_alu_out;
    assign carry   = r_carry;
    assign zero    = r_zero;
    assign busy    = r_busy;
    assign done    = r_done;

    // Single-cycle result and flag; the extra MSB of add/sub is carry/borrow
    always_comb begin
        w_add      = {1'b0, accum} + {1'b0, data};
        w_sub      = {1'b0, accum} - {1'b0, data};
        w_op_res   = accum;
        w_op_carry = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_op_res   = w_add[WIDTH-1:0];
                w_op_carry = w_add[WIDTH];
            end
            OP_SUB: begin
                w_op_res   = w_sub[WIDTH-1:0];
                w_op_carry = w_sub[WIDTH];
            end
            OP_AND:  w_op_res = accum & data;
            OP_XOR:  w_op_res = accum ^ data;
            OP_LDA:  w_op_res = data;
            default: w_op_res = accum;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
    assign w_prod_sum = r_prod + (r_mplier[0] ? r_mcand : PW'(0));

    // Next-state and next-output logic
    always_comb begin
        w_state   = r_state;
        w_mcand   = r_mcand;
        w_mplier  = r_mplier;
        w_prod    = r_prod;
        w_cnt     = r_cnt;
        w_alu_out = r_alu_out;
        w_carry   = r_carry;
        w_zero    = r_zero;
        w_busy    = r_busy;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        w_mcand  = PW'(accum);
                        w_mplier = data;
                        w_prod   = '0;
                        w_cnt    = '0;
                        w_busy   = 1'b1;
                        w_state  = S_MUL;
                    end else begin
                        w_alu_out = w_op_res;
                        w_carry   = w_op_carry;
                        w_zero    = (w_op_res == '0);
                        w_done    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                w_prod   = w_prod_sum;
                w_mcand  = r_mcand << 1;
                w_mplier = r_mplier >> 1;
                w_cnt    = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_alu_out = w_prod_sum[WIDTH-1:0];
                    w_carry   = |w_prod_sum[PW-1:WIDTH];
                    w_zero    = (w_prod_sum[WIDTH-1:0] == '0);
                    w_done    = 1'b1;
                    w_busy    = 1'b0;
                    w_state   = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_alu_out <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_mcand   <= w_mcand;
            r_mplier  <= w_mplier;
            r_prod    <= w_prod;
            r_cnt     <= w_cnt;
            r_alu_out <= w_alu_out;
            r_carry   <= w_carry;
            r_zero    <= w_zero;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: transaction-level reference model with per-cycle comparison,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] accum;
    logic [W-1:0] data;
    logic [W-1:0] alu_out;
    logic         carry;
    logic         zero;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .opcode  (opcode),
        .accum   (accum),
        .data    (data),
        .alu_out (alu_out),
        .carry   (carry),
        .zero    (zero),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {flag, result} for any opcode computed with plain integer arithmetic
    function automatic logic [W:0] ref_op(input int op, input int a, input int b);
        longint p;
        int     res;
        int     fl;
        res = a;
        fl  = 0;
        case (op)
            2: begin res = (a + b) % 256; fl = (a + b > 255) ? 1 : 0; end
            3: res = a & b;
            4: res = a ^ b;
            5: res = b;
            8: begin p = longint'(a) * longint'(b); res = int'(p % 256); fl = (p / 256 != 0) ? 1 : 0; end
            9: begin res = (a - b + 256) % 256; fl = (b > a) ? 1 : 0; end
            default: res = a;
        endcase
        return {fl[0], res[W-1:0]};
    endfunction

    // Behavioural model: a MUL occupies WIDTH busy cycles, everything else completes at once
    logic [W-1:0] e_out;
    logic         e_c, e_z, e_busy, e_done;
    int           m_left;
    int           m_a, m_b;

    initial begin
        logic [W:0] r;
        e_out = '0; e_c = 0; e_z = 0; e_busy = 0; e_done = 0; m_left = 0; m_a = 0; m_b = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                e_out = '0; e_c = 0; e_z = 0; e_busy = 0; e_done = 0; m_left = 0;
            end else begin
                e_done = 0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        r = ref_op(8, m_a, m_b);
                        e_out = r[W-1:0]; e_c = r[W]; e_z = (r[W-1:0] == 0); e_done = 1;
                    end
                end else if (start) begin
                    if (opcode == 4'd8) begin
                        m_a = int'(accum); m_b = int'(data); m_left = W;
                    end else begin
                        r = ref_op(int'(opcode), int'(accum), int'(data));
                        e_out = r[W-1:0]; e_c = r[W]; e_z = (r[W-1:0] == 0); e_done = 1;
                    end
                end
                e_busy = (m_left != 0);
            end
        end
    end

    // Every-cycle comparison shortly after the active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("m_alu_out", alu_out, e_out);
            chk("m_carry", W'(carry), W'(e_c));
            chk("m_zero", W'(zero), W'(e_z));
            chk("m_busy", W'(busy), W'(e_busy));
            chk("m_done", W'(done), W'(e_done));
        end
    end

    task automatic drive(input logic st, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d);
        start = st; opcode = op; accum = a; data = d;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 4'd0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_alu_out", alu_out, 8'h00);
        chk("rst_done", W'(done), 8'h00);
        chk("rst_busy", W'(busy), 8'h00);
        rst = 1'b1;

        // ADD with carry-out, then hold
        @(negedge clk); drive(1, 4'b0010, 8'hF0, 8'h20);
        @(negedge clk);
        chk("add_done", W'(done), 8'h01);
        chk("add_out", alu_out, 8'h10);
        chk("add_carry", W'(carry), 8'h01);
        chk("add_zero", W'(zero), 8'h00);
        start = 0;
        @(negedge clk);
        chk("add_done_low", W'(done), 8'h00);
        chk("add_hold", alu_out, 8'h10);

        // SUB equal then borrow, back to back
        drive(1, 4'b1001, 8'h05, 8'h05);
        @(negedge clk);
        chk("sub_eq_out", alu_out, 8'h00);
        chk("sub_eq_zero", W'(zero), 8'h01);
        chk("sub_eq_carry", W'(carry), 8'h00);
        drive(1, 4'b1001, 8'h03, 8'h05);
        @(negedge clk);
        chk("sub_bw_out", alu_out, 8'hFE);
        chk("sub_bw_carry", W'(carry), 8'h01);
        chk("sub_bw_zero", W'(zero), 8'h00);
        start = 0;

        // MUL timing with operand change and ignored start while busy
        @(negedge clk); drive(1, 4'b1000, 8'h0D, 8'h0B);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                chk("mul_busy", W'(busy), 8'h01);
                chk("mul_nodone", W'(done), 8'h00);
            end else if (k == 9) begin
                chk("mul_done", W'(done), 8'h01);
                chk("mul_busy_off", W'(busy), 8'h00);
                chk("mul_out", alu_out, 8'h8F);
                chk("mul_carry", W'(carry), 8'h00);
            end else begin
                chk("mul_single_done", W'(done), 8'h00);
            end
            if (k == 1) start = 0;
            if (k == 3) data = 8'hFF;
            if (k == 4) start = 1;
            if (k == 5) start = 0;
        end

        // MUL overflow
        @(negedge clk); drive(1, 4'b1000, 8'h10, 8'h10);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start = 0;
            if (k == 9) begin
                chk("ovf_done", W'(done), 8'h01);
                chk("ovf_out", alu_out, 8'h00);
                chk("ovf_carry", W'(carry), 8'h01);
                chk("ovf_zero", W'(zero), 8'h01);
            end
        end

        // Reset mid-MUL aborts it
        @(negedge clk); drive(1, 4'b1000, 8'h0D, 8'h0B);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) start = 0;
            if (k == 4) rst = 0;
        end
        @(negedge clk);
        chk("abort_out", alu_out, 8'h00);
        chk("abort_carry", W'(carry), 8'h00);
        chk("abort_zero", W'(zero), 8'h00);
        chk("abort_busy", W'(busy), 8'h00);
        chk("abort_done", W'(done), 8'h00);
        rst = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_done", W'(done), 8'h00);
        end
        drive(1, 4'b0101, 8'h00, 8'h5A);
        @(negedge clk);
        chk("lda_done", W'(done), 8'h01);
        chk("lda_out", alu_out, 8'h5A);
        start = 0;

        // LDA with start held three cycles
        @(negedge clk); drive(1, 4'b0101, 8'h00, 8'h33);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3) begin
                chk("b2b_done", W'(done), 8'h01);
                chk("b2b_out", alu_out, 8'h33);
            end else begin
                chk("b2b_done_end", W'(done), 8'h00);
            end
            if (k == 3) start = 0;
        end

        // XOR issued in the done cycle of a MUL
        drive(1, 4'b1000, 8'h03, 8'h05);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 0;
            if (k == 9) begin
                chk("b2b_mul_done", W'(done), 8'h01);
                chk("b2b_mul_out", alu_out, 8'h0F);
                drive(1, 4'b0100, 8'h33, 8'h33);
            end
            if (k == 10) begin
                chk("b2b_xor_done", W'(done), 8'h01);
                chk("b2b_xor_out", alu_out, 8'h00);
                chk("b2b_xor_zero", W'(zero), 8'h01);
                start = 0;
            end
        end
        @(negedge clk);
        chk("b2b_xor_single", W'(done), 8'h00);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 99) != 0);
            start  = 1'($urandom_range(0, 1));
            opcode = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            accum  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            data   = ($urandom_range(0, 7) == 0) ? accum : 8'($urandom);
        end
        @(negedge clk);
        start = 0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
